instr_fetch: RTL and testbench

//   Upstream stage of the decode/control FSM. Owns the program counter and issues

---
 rtl/instr_fetch.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding byte reads,
// buffers fetched bytes with their PCs and hands them to the decoder.
module instr_fetch #(
  parameter int unsigned        ADDR_W    = 8,
  parameter int unsigned        BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i,
  output logic [7:0]        instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e            state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] pc_q;

  logic [7:0]        buf_data_q [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_pc_q   [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [7:0]        instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q;

  logic              push, pop;
  logic [OCC_W-1:0]  occ_after;
  logic              space;

  // FIFO bookkeeping; a redirect flushes and overrides any pop or push.
  always_comb begin
    push      = (state_q == S_REQ) && mem_ack_i && !redirect_i;
    pop       = instr_valid_q && instr_ready_i && !redirect_i;
    occ_after = OCC_W'(count_q) + OCC_W'(1) - OCC_W'(pop);
    space     = count_q < CNT_W'(BUF_DEPTH);

    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Registered head: forward the byte being written if it becomes the head.
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (count_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        instr_d    = mem_rdata_i;
        instr_pc_d = pc_q;
      end else begin
        instr_d    = buf_data_q[rd_ptr_d];
        instr_pc_d = buf_pc_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= mem_rdata_i;
      buf_pc_q[wr_ptr_q]   <= pc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= (count_d != '0);

      case (state_q)
        S_IDLE: begin
          if (redirect_i) begin
            pc_q <= redirect_pc_i;
          end else if (!halt_i && space) begin
            state_q    <= S_REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            if (redirect_i) begin
              pc_q      <= redirect_pc_i;
              state_q   <= S_IDLE;
              mem_req_q <= 1'b0;
            end else begin
              pc_q <= pc_q + ADDR_W'(1);
              if (!halt_i && (occ_after < OCC_W'(BUF_DEPTH))) begin
                mem_addr_q <= pc_q + ADDR_W'(1);
              end else begin
                state_q   <= S_IDLE;
                mem_req_q <= 1'b0;
              end
            end
          end else if (redirect_i) begin
            // Request already issued: let it finish, then throw the data away.
            pc_q    <= redirect_pc_i;
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (redirect_i) pc_q <= redirect_pc_i;
          if (mem_ack_i) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = instr_valid_q;
  assign pc_o          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory byte at address a is 8'h41 + a*8'h11.
module tb_instr_fetch;

  logic       clk;
  logic       rst;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       halt;
  logic [7:0] pc;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q [$];

  instr_fetch #(.ADDR_W(8), .BUF_DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .halt_i        (halt),
    .pc_o          (pc)
  );

  function automatic logic [7:0] mem_byte(input logic [7:0] a);
    logic [7:0] m;
    m = a * 8'h11;
    return 8'h41 + m;
  endfunction

  assign mem_rdata = mem_byte(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    halt = 0; redirect = 0; redirect_pc = 8'h00; mem_ack = 1; instr_ready = 1;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
    n_cmp++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", pc); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if ({instr_pc, instr} !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", {instr_pc, instr}); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [15:0] e;
    exp_q.delete();
    halt = 0; redirect = 0; mem_ack = 1; instr_ready = 1;
    do_reset();
    exp_q.push_back({8'h00, 8'h41});
    exp_q.push_back({8'h01, 8'h52});
    exp_q.push_back({8'h02, 8'h63});
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL stream_first_req: got %b/%h want 1/00", mem_req, mem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid: got %b want 0", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (mem_addr !== 8'(k + 1)) begin n_fail++; $display("FAIL stream_addr%0d: got %h want %h", k, mem_addr, 8'(k + 1)); end
      n_cmp++;
      if (!instr_valid) begin
        n_fail++; $display("FAIL stream_valid%0d: got 0 want 1", k);
      end else begin
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin n_fail++; $display("FAIL stream_instr%0d: got %h want %h", k, {instr_pc, instr}, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    logic seen;
    exp_q.delete();
    halt = 0; redirect = 0; mem_ack = 1; instr_ready = 0;
    do_reset();
    repeat (4) tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_drop: got %b want 0", mem_req); end
    n_cmp++; if (pc !== 8'h02) begin n_fail++; $display("FAIL bp_pc: got %h want 02", pc); end
    exp_q.push_back({8'h00, 8'h41});
    exp_q.push_back({8'h01, 8'h52});
    exp_q.push_back({8'h02, 8'h63});
    exp_q.push_back({8'h03, 8'h74});
    seen = 1'b0;
    instr_ready = 1;
    for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
      if (mem_req && !seen) begin
        seen = 1'b1;
        n_cmp++; if (mem_addr !== 8'h02) begin n_fail++; $display("FAIL bp_resume_addr: got %h want 02", mem_addr); end
      end
      if (instr_valid) begin
        e = exp_q.pop_front();
        n_cmp++; if ({instr_pc, instr} !== e) begin n_fail++; $display("FAIL bp_instr: got %h want %h", {instr_pc, instr}, e); end
      end
      tick();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_ack_delay();
    logic [15:0] e;
    exp_q.delete();
    halt = 1; redirect = 0; mem_ack = 0; instr_ready = 1;
    do_reset();
    redirect = 1; redirect_pc = 8'h05;
    tick();
    redirect = 0; halt = 0;
    tick();
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h05}) begin n_fail++; $display("FAIL delay_hold%0d: got %b/%h want 1/05", c, mem_req, mem_addr); end
      if (c < 3) tick();
    end
    exp_q.push_back({8'h05, mem_byte(8'h05)});
    mem_ack = 1;
    tick();
    mem_ack = 0;
    n_cmp++;
    if (!instr_valid) begin
      n_fail++; $display("FAIL delay_valid: got 0 want 1");
    end else begin
      e = exp_q.pop_front();
      if ({instr_pc, instr} !== e) begin n_fail++; $display("FAIL delay_instr: got %h want %h", {instr_pc, instr}, e); end
    end
    n_cmp++; if (mem_addr !== 8'h06) begin n_fail++; $display("FAIL delay_next_addr: got %h want 06", mem_addr); end
    tick();
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL delay_single_push: got %b want 0", instr_valid); end
  endtask

  task automatic test_redirect();
    logic [15:0] e;
    exp_q.delete();
    halt = 1; redirect = 0; mem_ack = 0; instr_ready = 0;
    do_reset();
    redirect = 1; redirect_pc = 8'h04;
    tick();
    redirect = 0; halt = 0; mem_ack = 1;
    tick();
    n_cmp++; if (mem_addr !== 8'h04) begin n_fail++; $display("FAIL redir_setup_addr: got %h want 04", mem_addr); end
    exp_q.push_back({8'h04, mem_byte(8'h04)});
    tick();
    mem_ack = 0;
    n_cmp++;
    if (!instr_valid) begin
      n_fail++; $display("FAIL redir_setup_valid: got 0 want 1");
    end else begin
      e = exp_q.pop_front();
      if ({instr_pc, instr} !== e) begin n_fail++; $display("FAIL redir_setup_instr: got %h want %h", {instr_pc, instr}, e); end
    end
    tick();
    redirect = 1; redirect_pc = 8'h80;
    tick();
    redirect = 0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b want 0", instr_valid); end
    n_cmp++; if ({mem_req, mem_addr, pc} !== {1'b1, 8'h05, 8'h80}) begin n_fail++; $display("FAIL redir_drop: got %b/%h/%h want 1/05/80", mem_req, mem_addr, pc); end
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h05}) begin n_fail++; $display("FAIL redir_drop_hold: got %b/%h want 1/05", mem_req, mem_addr); end
    mem_ack = 1;
    tick();
    n_cmp++; if ({mem_req, instr_valid} !== 2'b00) begin n_fail++; $display("FAIL redir_discard: got req %b valid %b want 0/0", mem_req, instr_valid); end
    tick();
    n_cmp++; if ({mem_req, mem_addr, instr_valid} !== {1'b1, 8'h80, 1'b0}) begin n_fail++; $display("FAIL redir_new_req: got %b/%h/%b want 1/80/0", mem_req, mem_addr, instr_valid); end
    exp_q.push_back({8'h80, mem_byte(8'h80)});
    tick();
    n_cmp++;
    if (!instr_valid) begin
      n_fail++; $display("FAIL redir_new_valid: got 0 want 1");
    end else begin
      e = exp_q.pop_front();
      if ({instr_pc, instr} !== e) begin n_fail++; $display("FAIL redir_new_instr: got %h want %h", {instr_pc, instr}, e); end
    end
  endtask

  task automatic test_wrap_halt();
    logic [15:0] e;
    exp_q.delete();
    halt = 1; redirect = 0; mem_ack = 1; instr_ready = 1;
    do_reset();
    redirect = 1; redirect_pc = 8'hFE;
    tick();
    redirect = 0; halt = 0;
    exp_q.push_back({8'hFE, mem_byte(8'hFE)});
    exp_q.push_back({8'hFF, mem_byte(8'hFF)});
    tick();
    n_cmp++; if (mem_addr !== 8'hFE) begin n_fail++; $display("FAIL wrap_addr_fe: got %h want fe", mem_addr); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (!instr_valid) begin
        n_fail++; $display("FAIL wrap_valid%0d: got 0 want 1", k);
      end else begin
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin n_fail++; $display("FAIL wrap_instr%0d: got %h want %h", k, {instr_pc, instr}, e); end
      end
    end
    n_cmp++; if ({mem_addr, pc} !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr_00: got %h/%h want 00/00", mem_addr, pc); end
    halt = 1; mem_ack = 0;
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL halt_keeps_req: got %b/%h want 1/00", mem_req, mem_addr); end
    mem_ack = 1;
    exp_q.push_back({8'h00, 8'h41});
    tick();
    n_cmp++; if ({mem_req, pc} !== {1'b0, 8'h01}) begin n_fail++; $display("FAIL halt_complete: got %b/%h want 0/01", mem_req, pc); end
    n_cmp++;
    if (!instr_valid) begin
      n_fail++; $display("FAIL halt_valid: got 0 want 1");
    end else begin
      e = exp_q.pop_front();
      if ({instr_pc, instr} !== e) begin n_fail++; $display("FAIL halt_instr: got %h want %h", {instr_pc, instr}, e); end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL halt_idle%0d: got %b want 0", c, mem_req); end
    end
    redirect = 1; redirect_pc = 8'h40;
    tick();
    redirect = 0;
    n_cmp++; if ({pc, mem_req, instr_valid} !== {8'h40, 2'b00}) begin n_fail++; $display("FAIL halt_redirect: got %h/%b/%b want 40/0/0", pc, mem_req, instr_valid); end
    tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL halt_still: got %b want 0", mem_req); end
    halt = 0;
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h40}) begin n_fail++; $display("FAIL halt_release: got %b/%h want 1/40", mem_req, mem_addr); end
  endtask

  task automatic test_reset_mid();
    halt = 0; redirect = 0; mem_ack = 1; instr_ready = 0;
    do_reset();
    tick();
    tick();
    mem_ack = 0;
    redirect = 1; redirect_pc = 8'h33;
    tick();
    redirect = 0;
    n_cmp++; if ({mem_req, pc} !== {1'b1, 8'h33}) begin n_fail++; $display("FAIL rmid_drop: got %b/%h want 1/33", mem_req, pc); end
    rst = 1;
    tick();
    n_cmp++; if ({mem_req, mem_addr, pc, instr_valid, instr_pc, instr} !== 34'h0) begin n_fail++; $display("FAIL rmid_drop_reset: got %b/%h/%h/%b/%h/%h want all 0", mem_req, mem_addr, pc, instr_valid, instr_pc, instr); end
    rst = 0; mem_ack = 1;
    tick();
    tick();
    mem_ack = 0;
    n_cmp++; if ({mem_req, instr_valid} !== 2'b11) begin n_fail++; $display("FAIL rmid_req_setup: got %b/%b want 1/1", mem_req, instr_valid); end
    rst = 1;
    tick();
    rst = 0;
    n_cmp++; if ({mem_req, mem_addr, pc, instr_valid, instr_pc, instr} !== 34'h0) begin n_fail++; $display("FAIL rmid_req_reset: got %b/%h/%h/%b/%h/%h want all 0", mem_req, mem_addr, pc, instr_valid, instr_pc, instr); end
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL rmid_restart: got %b/%h want 1/00", mem_req, mem_addr); end
  endtask

  initial begin
    rst = 1; halt = 0; redirect = 0; redirect_pc = 8'h00; mem_ack = 0; instr_ready = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_ack_delay();
    test_redirect();
    test_wrap_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
